// File: rtl/inst_buffer_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// One queue entry carries the instruction word, its PC and the predicted-taken bit.
package inst_buffer_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic              pred;
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } ibuf_entry_t;

  localparam int ENTRY_W = $bits(ibuf_entry_t);

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  function automatic ibuf_entry_t make_entry(input logic [INST_W-1:0] inst,
                                             input logic [ADDR_W-1:0] addr,
                                             input logic              pred);
    ibuf_entry_t e;
    e.inst = inst;
    e.addr = addr;
    e.pred = pred;
    return e;
  endfunction

endpackage

// File: rtl/inst_buffer_ram.sv
// Payload storage for the instruction queue: two write ports, two asynchronous read ports.
// Contents are never reset; validity is tracked entirely by the pointer logic in the top.
module inst_buffer_ram
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we1_i,
  input  logic [AW-1:0] waddr1_i,
  input  ibuf_entry_t   wdata1_i,
  input  logic          we2_i,
  input  logic [AW-1:0] waddr2_i,
  input  ibuf_entry_t   wdata2_i,
  input  logic [AW-1:0] raddr1_i,
  input  logic [AW-1:0] raddr2_i,
  output ibuf_entry_t   rdata1_o,
  output ibuf_entry_t   rdata2_o
);

  ibuf_entry_t mem_q [DEPTH];
  ibuf_entry_t mem_d [DEPTH];

  // Port 2 is applied last so it wins on an address collision.
  always_comb begin
    mem_d = mem_q;
    if (we1_i) mem_d[waddr1_i] = wdata1_i;
    if (we2_i) mem_d[waddr2_i] = wdata2_i;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch (2 inst/cycle) and decode (1 or 2 inst/cycle).
// Handles write compaction, overflow dropping, dequeue clamping, stall and flush.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AFULL_GAP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              fifo_we1_i,
  input  logic              fifo_we2_i,
  input  logic [INST_W-1:0] fifo_wdata1_i,
  input  logic [INST_W-1:0] fifo_wdata2_i,
  input  logic [ADDR_W-1:0] fifo_waddr1_i,
  input  logic [ADDR_W-1:0] fifo_waddr2_i,
  input  logic              fifo_wpred1_i,
  input  logic              fifo_wpred2_i,
  input  logic              issue_i,
  input  logic              issue_mode_i,
  output logic [INST_W-1:0] issue_inst1_o,
  output logic [INST_W-1:0] issue_inst2_o,
  output logic [ADDR_W-1:0] issue_addr1_o,
  output logic [ADDR_W-1:0] issue_addr2_o,
  output logic              issue_pred1_o,
  output logic              issue_pred2_o,
  output logic              issue_valid1_o,
  output logic              issue_valid2_o,
  output logic              buffer_full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_GAP);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW-1:0] free_cnt;
  logic [1:0]    n_req;
  logic [1:0]    n_w;
  logic [1:0]    deq_req;
  logic [1:0]    deq;
  logic          we1_ok;
  logic          we2_ok;
  logic [AW-1:0] waddr1;
  logic [AW-1:0] waddr2;
  logic [AW-1:0] head_p1;

  ibuf_entry_t   wentry1;
  ibuf_entry_t   wentry2;
  ibuf_entry_t   rentry1;
  ibuf_entry_t   rentry2;

  // Slot 2 is dropped before slot 1 when only one entry is free.
  always_comb begin
    free_cnt = DEPTH_C - count_q;
    n_req    = {1'b0, fifo_we1_i} + {1'b0, fifo_we2_i};
    we1_ok   = fifo_we1_i && (free_cnt != '0) && !flush_i;
    we2_ok   = fifo_we2_i && (free_cnt > CW'(fifo_we1_i)) && !flush_i;
    n_w      = {1'b0, we1_ok} + {1'b0, we2_ok};
    waddr1   = tail_q;
    waddr2   = tail_q + AW'(we1_ok);
    wentry1  = make_entry(fifo_wdata1_i, fifo_waddr1_i, fifo_wpred1_i);
    wentry2  = make_entry(fifo_wdata2_i, fifo_waddr2_i, fifo_wpred2_i);

    deq_req = '0;
    if (issue_i && !stall_i) deq_req = issue_mode_i ? 2'd2 : 2'd1;
    deq = (CW'(deq_req) > count_q) ? count_q[1:0] : deq_req;

    head_d  = head_q + AW'(deq);
    tail_d  = tail_q + AW'(n_w);
    count_d = count_q + CW'(n_w) - CW'(deq);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_p1 = head_q + AW'(1);

  inst_buffer_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk      (clk),
    .we1_i    (we1_ok && !rst),
    .waddr1_i (waddr1),
    .wdata1_i (wentry1),
    .we2_i    (we2_ok && !rst),
    .waddr2_i (waddr2),
    .wdata2_i (wentry2),
    .raddr1_i (head_q),
    .raddr2_i (head_p1),
    .rdata1_o (rentry1),
    .rdata2_o (rentry2)
  );

  // Data is zeroed whenever the matching slot holds nothing issuable.
  always_comb begin
    issue_valid1_o = (count_q >= CW'(1));
    issue_valid2_o = (count_q >= CW'(2));
    issue_inst1_o  = issue_valid1_o ? rentry1.inst : ZERO_WORD;
    issue_addr1_o  = issue_valid1_o ? rentry1.addr : '0;
    issue_pred1_o  = issue_valid1_o & rentry1.pred;
    issue_inst2_o  = issue_valid2_o ? rentry2.inst : ZERO_WORD;
    issue_addr2_o  = issue_valid2_o ? rentry2.addr : '0;
    issue_pred2_o  = issue_valid2_o & rentry2.pred;
    buffer_full_o  = (free_cnt < AFULL_C);
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst || flush_i)
                                 (CW'(n_req) <= free_cnt))
    else $warning("inst_buffer: fetch write dropped, queue has no free entry");

  count_chk: assert property (@(posedge clk) disable iff (rst) (count_q <= DEPTH_C))
    else $error("inst_buffer: occupancy exceeds DEPTH");

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: reset, dual write/issue, fill/overflow, wrap-around,
// stall and flush, each scenario in its own task with hand-computed expectations.
module tb_inst_buffer;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        stall_i;
  logic        we1, we2;
  logic [31:0] wdata1, wdata2, waddr1, waddr2;
  logic        wpred1, wpred2;
  logic        issue, issue_mode;
  logic [31:0] inst1, inst2, addr1, addr2;
  logic        pred1, pred2, valid1, valid2, full;

  int errors = 0;
  int checks = 0;

  inst_buffer #(.DEPTH(16), .AFULL_GAP(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .stall_i        (stall_i),
    .fifo_we1_i     (we1),
    .fifo_we2_i     (we2),
    .fifo_wdata1_i  (wdata1),
    .fifo_wdata2_i  (wdata2),
    .fifo_waddr1_i  (waddr1),
    .fifo_waddr2_i  (waddr2),
    .fifo_wpred1_i  (wpred1),
    .fifo_wpred2_i  (wpred2),
    .issue_i        (issue),
    .issue_mode_i   (issue_mode),
    .issue_inst1_o  (inst1),
    .issue_inst2_o  (inst2),
    .issue_addr1_o  (addr1),
    .issue_addr2_o  (addr2),
    .issue_pred1_o  (pred1),
    .issue_pred2_o  (pred2),
    .issue_valid1_o (valid1),
    .issue_valid2_o (valid2),
    .buffer_full_o  (full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush_i = 0; stall_i = 0; we1 = 0; we2 = 0;
    wdata1 = '0; wdata2 = '0; waddr1 = '0; waddr2 = '0;
    wpred1 = 0; wpred2 = 0; issue = 0; issue_mode = 0;
  endtask

  task automatic set_write2(input logic [31:0] pc);
    we1 = 1; we2 = 1;
    waddr1 = pc;      wdata1 = inst_of(pc);
    waddr2 = pc + 4;  wdata2 = inst_of(pc + 4);
  endtask

  task automatic set_write1(input logic [31:0] pc);
    we1 = 1; we2 = 0;
    waddr1 = pc; wdata1 = inst_of(pc);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    set_write2(32'hFFFF_0000);
    repeat (2) cycle();
    clear_inputs();
    rst = 0;
    repeat (3) cycle();
    checks++; if (valid1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid1: got %b want 0", valid1); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid2: got %b want 0", valid2); end
    checks++; if ({inst1, inst2} !== 64'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h %h want 0", inst1, inst2); end
    checks++; if ({addr1, addr2} !== 64'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h %h want 0", addr1, addr2); end
    checks++; if ({pred1, pred2} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pred: got %b%b want 00", pred1, pred2); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b want 0", full); end
  endtask

  task automatic test_dual_write_issue();
    we1 = 1; wdata1 = 32'h2401_0001; waddr1 = 32'hBFC0_0000; wpred1 = 1;
    we2 = 1; wdata2 = 32'h2402_0002; waddr2 = 32'hBFC0_0004; wpred2 = 0;
    #1;
    checks++; if (valid1 !== 1'b0) begin errors++; $display("[TB] FAIL no_bypass: got valid1=%b want 0", valid1); end
    cycle();
    clear_inputs();
    checks++; if ({valid1, valid2} !== 2'b11) begin errors++; $display("[TB] FAIL dual_valid: got %b%b want 11", valid1, valid2); end
    checks++; if (inst1 !== 32'h2401_0001) begin errors++; $display("[TB] FAIL dual_inst1: got %h want 24010001", inst1); end
    checks++; if (addr1 !== 32'hBFC0_0000) begin errors++; $display("[TB] FAIL dual_addr1: got %h want bfc00000", addr1); end
    checks++; if (inst2 !== 32'h2402_0002) begin errors++; $display("[TB] FAIL dual_inst2: got %h want 24020002", inst2); end
    checks++; if (addr2 !== 32'hBFC0_0004) begin errors++; $display("[TB] FAIL dual_addr2: got %h want bfc00004", addr2); end
    checks++; if ({pred1, pred2} !== 2'b10) begin errors++; $display("[TB] FAIL dual_pred: got %b%b want 10", pred1, pred2); end
    issue = 1; issue_mode = 1;
    cycle();
    clear_inputs();
    checks++; if ({valid1, valid2} !== 2'b00) begin errors++; $display("[TB] FAIL dual_drained: got %b%b want 00", valid1, valid2); end
    checks++; if (inst1 !== 32'h0) begin errors++; $display("[TB] FAIL dual_zero_inst: got %h want 0", inst1); end
  endtask

  task automatic test_fill_overflow();
    logic exp_full;
    for (int k = 0; k < 8; k++) begin
      set_write2(32'h1000 + 32'(8 * k));
      cycle();
      exp_full = ((16 - 2 * (k + 1)) < 4);
      checks++; if (full !== exp_full) begin errors++; $display("[TB] FAIL fill_full_%0d: got %b want %b", k, full, exp_full); end
    end
    for (int k = 0; k < 2; k++) begin
      set_write2(32'hDEAD_0000 + 32'(8 * k));
      cycle();
    end
    clear_inputs();
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL overflow_full: got %b want 1", full); end
    for (int i = 0; i < 16; i++) begin
      exp_full = (i < 4);
      checks++; if (valid1 !== 1'b1) begin errors++; $display("[TB] FAIL drain_valid_%0d: got %b want 1", i, valid1); end
      checks++; if (addr1 !== 32'h1000 + 32'(4 * i)) begin errors++; $display("[TB] FAIL drain_addr_%0d: got %h want %h", i, addr1, 32'h1000 + 32'(4 * i)); end
      checks++; if (full !== exp_full) begin errors++; $display("[TB] FAIL drain_full_%0d: got %b want %b", i, full, exp_full); end
      issue = 1; issue_mode = 0;
      cycle();
    end
    clear_inputs();
    checks++; if (valid1 !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got %b want 0", valid1); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 15; i++) begin
      set_write1(32'h2000 + 32'(4 * i));
      cycle();
    end
    clear_inputs();
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL wrap_full15: got %b want 1", full); end
    for (int i = 0; i < 15; i++) begin
      checks++; if (addr1 !== 32'h2000 + 32'(4 * i)) begin errors++; $display("[TB] FAIL pop_addr_%0d: got %h want %h", i, addr1, 32'h2000 + 32'(4 * i)); end
      issue = 1; issue_mode = 0;
      cycle();
    end
    clear_inputs();
    checks++; if (valid1 !== 1'b0) begin errors++; $display("[TB] FAIL pop_empty: got %b want 0", valid1); end
    for (int c = 0; c < 8; c++) begin
      set_write2(32'h3000 + 32'(8 * c));
      issue = 1; issue_mode = 1;
      if (c == 0) begin
        checks++; if (valid1 !== 1'b0) begin errors++; $display("[TB] FAIL wrap_first_empty: got %b want 0", valid1); end
      end else begin
        checks++; if ({valid1, valid2} !== 2'b11) begin errors++; $display("[TB] FAIL wrap_valid_%0d: got %b%b want 11", c, valid1, valid2); end
        checks++; if (addr1 !== 32'h3000 + 32'(8 * (c - 1))) begin errors++; $display("[TB] FAIL wrap_addr1_%0d: got %h want %h", c, addr1, 32'h3000 + 32'(8 * (c - 1))); end
        checks++; if (addr2 !== 32'h3004 + 32'(8 * (c - 1))) begin errors++; $display("[TB] FAIL wrap_addr2_%0d: got %h want %h", c, addr2, 32'h3004 + 32'(8 * (c - 1))); end
      end
      cycle();
    end
    clear_inputs();
    checks++; if ({addr1, addr2} !== {32'h3038, 32'h303C}) begin errors++; $display("[TB] FAIL wrap_last: got %h %h want 00003038 0000303c", addr1, addr2); end
    issue = 1; issue_mode = 1;
    cycle();
    clear_inputs();
    checks++; if (valid1 !== 1'b0) begin errors++; $display("[TB] FAIL wrap_empty: got %b want 0", valid1); end
    set_write1(32'h3800);
    cycle();
    clear_inputs();
    checks++; if ({valid1, valid2} !== 2'b10) begin errors++; $display("[TB] FAIL clamp_valid: got %b%b want 10", valid1, valid2); end
    checks++; if (addr2 !== 32'h0) begin errors++; $display("[TB] FAIL clamp_addr2_zero: got %h want 0", addr2); end
    issue = 1; issue_mode = 1;
    cycle();
    clear_inputs();
    checks++; if (valid1 !== 1'b0) begin errors++; $display("[TB] FAIL clamp_empty: got %b want 0", valid1); end
  endtask

  task automatic test_stall();
    int n;
    set_write2(32'h4000); cycle();
    set_write2(32'h4008); cycle();
    set_write1(32'h4010); cycle();
    clear_inputs();
    checks++; if ({addr1, addr2} !== {32'h4000, 32'h4004}) begin errors++; $display("[TB] FAIL stall_pre: got %h %h want 00004000 00004004", addr1, addr2); end
    for (int s = 0; s < 3; s++) begin
      stall_i = 1; issue = 1; issue_mode = 1;
      set_write2(32'h4014 + 32'(8 * s));
      cycle();
      checks++; if (addr1 !== 32'h4000) begin errors++; $display("[TB] FAIL stall_addr_%0d: got %h want 00004000", s, addr1); end
      checks++; if (inst1 !== inst_of(32'h4000)) begin errors++; $display("[TB] FAIL stall_inst_%0d: got %h want %h", s, inst1, inst_of(32'h4000)); end
    end
    clear_inputs();
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL stall_full11: got %b want 0", full); end
    n = 0;
    for (int i = 0; i < 20 && valid1 === 1'b1; i++) begin
      checks++; if (addr1 !== 32'h4000 + 32'(4 * n)) begin errors++; $display("[TB] FAIL stall_drain_%0d: got %h want %h", n, addr1, 32'h4000 + 32'(4 * n)); end
      n++;
      issue = 1; issue_mode = 0;
      cycle();
    end
    clear_inputs();
    checks++; if (n !== 11) begin errors++; $display("[TB] FAIL stall_count: got %0d entries want 11", n); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      set_write2(32'h6000 + 32'(8 * i));
      cycle();
    end
    set_write1(32'h6020); cycle();
    clear_inputs();
    checks++; if ({valid2, addr1} !== {1'b1, 32'h6000}) begin errors++; $display("[TB] FAIL flush_pre: got %b %h want 1 00006000", valid2, addr1); end
    flush_i = 1;
    set_write2(32'h6100);
    issue = 1; issue_mode = 1;
    cycle();
    clear_inputs();
    checks++; if ({valid1, valid2} !== 2'b00) begin errors++; $display("[TB] FAIL flush_valid: got %b%b want 00", valid1, valid2); end
    checks++; if (addr1 !== 32'h0) begin errors++; $display("[TB] FAIL flush_addr: got %h want 0", addr1); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL flush_full: got %b want 0", full); end
    we2 = 1; waddr2 = 32'h7000; wdata2 = inst_of(32'h7000); wpred2 = 1;
    cycle();
    clear_inputs();
    checks++; if ({valid1, valid2} !== 2'b10) begin errors++; $display("[TB] FAIL post_flush_valid: got %b%b want 10", valid1, valid2); end
    checks++; if (addr1 !== 32'h7000) begin errors++; $display("[TB] FAIL post_flush_addr: got %h want 00007000", addr1); end
    checks++; if (inst1 !== inst_of(32'h7000)) begin errors++; $display("[TB] FAIL post_flush_inst: got %h want %h", inst1, inst_of(32'h7000)); end
    checks++; if (pred1 !== 1'b1) begin errors++; $display("[TB] FAIL post_flush_pred: got %b want 1", pred1); end
    issue = 1; issue_mode = 0;
    cycle();
    clear_inputs();
    checks++; if (valid1 !== 1'b0) begin errors++; $display("[TB] FAIL post_flush_empty: got %b want 0", valid1); end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    $display("[TB] inst_buffer directed tests start");
    test_reset();
    test_dual_write_issue();
    test_fill_overflow();
    test_wrap();
    test_stall();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
